// File: rtl/pix_stream_pkg.sv
// rtl/pix_stream_pkg.sv - shared widths and default dimensions for the pixel stream framer
package pix_stream_pkg;

  localparam int DEF_DATA_W   = 8;
  localparam int DEF_CHANNELS = 3;
  localparam int DEF_IMG_W    = 512;
  localparam int DEF_IMG_H    = 512;
  localparam int DEF_DEPTH    = 16;

  function automatic int pix_w(input int data_w, input int channels);
    return data_w * channels;
  endfunction

  // Position counters need at least one bit even for a single-line frame.
  function automatic int pos_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int level_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/pix_fifo.sv
// rtl/pix_fifo.sv - show-ahead pixel FIFO with occupancy level
module pix_fifo
  import pix_stream_pkg::*;
#(
  parameter int WIDTH = 24,
  parameter int DEPTH = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_clear,
  input  logic                      i_wr_en,
  input  logic [WIDTH-1:0]          i_wr_data,
  input  logic                      i_rd_en,
  output logic [WIDTH-1:0]          o_rd_data,
  output logic [level_w(DEPTH)-1:0] o_level,
  output logic                      o_full,
  output logic                      o_empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LVL_W = level_w(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [LVL_W-1:0] r_level;
  logic             w_wr;
  logic             w_rd;

  assign o_full    = (r_level == LVL_W'(DEPTH));
  assign o_empty   = (r_level == '0);
  assign o_level   = r_level;
  assign o_rd_data = r_mem[r_rd_ptr];

  assign w_wr = i_wr_en && !o_full && !i_clear;
  assign w_rd = i_rd_en && !o_empty && !i_clear;

  // Storage is deliberately left unreset; out_valid masks stale contents.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= i_wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else if (i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_rd) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_wr, w_rd})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/pixel_stream_framer.sv
// rtl/pixel_stream_framer.sv - buffers a raster pixel stream and tags it with position and frame markers
module pixel_stream_framer
  import pix_stream_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int CHANNELS = DEF_CHANNELS,
  parameter int IMG_W    = DEF_IMG_W,
  parameter int IMG_H    = DEF_IMG_H,
  parameter int DEPTH    = DEF_DEPTH
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                clear,
  input  logic [pix_w(DATA_W, CHANNELS)-1:0]  in_pixel,
  input  logic                                in_valid,
  output logic                                in_ready,
  output logic [pix_w(DATA_W, CHANNELS)-1:0]  out_pixel,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [pos_w(IMG_W)-1:0]             out_x,
  output logic [pos_w(IMG_H)-1:0]             out_y,
  output logic                                out_sof,
  output logic                                out_eol,
  output logic                                out_eof,
  output logic [level_w(DEPTH)-1:0]           fifo_level,
  output logic                                frame_done,
  output logic [15:0]                         frame_count
);

  localparam int PIX_W = pix_w(DATA_W, CHANNELS);
  localparam int X_W   = pos_w(IMG_W);
  localparam int Y_W   = pos_w(IMG_H);

  logic [X_W-1:0] r_x;
  logic [Y_W-1:0] r_y;
  logic           r_frame_done;
  logic [15:0]    r_frame_count;
  logic           w_full;
  logic           w_empty;
  logic           w_in_xfer;
  logic           w_out_xfer;
  logic           w_last_x;
  logic           w_last_y;

  // rst_n gates in_ready so the source sees backpressure during reset.
  assign in_ready   = !w_full && !clear && rst_n;
  assign out_valid  = !w_empty;
  assign w_in_xfer  = in_valid && in_ready;
  assign w_out_xfer = out_valid && out_ready && !clear;

  pix_fifo #(
    .WIDTH (PIX_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_clear   (clear),
    .i_wr_en   (w_in_xfer),
    .i_wr_data (in_pixel),
    .i_rd_en   (w_out_xfer),
    .o_rd_data (out_pixel),
    .o_level   (fifo_level),
    .o_full    (w_full),
    .o_empty   (w_empty)
  );

  assign w_last_x = (r_x == X_W'(IMG_W - 1));
  assign w_last_y = (r_y == Y_W'(IMG_H - 1));

  assign out_x       = r_x;
  assign out_y       = r_y;
  assign out_sof     = out_valid && (r_x == '0) && (r_y == '0);
  assign out_eol     = out_valid && w_last_x;
  assign out_eof     = out_eol && w_last_y;
  assign frame_done  = r_frame_done;
  assign frame_count = r_frame_count;

  // frame_count survives clear so software can track frames across flushes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x           <= '0;
      r_y           <= '0;
      r_frame_done  <= 1'b0;
      r_frame_count <= '0;
    end else if (clear) begin
      r_x          <= '0;
      r_y          <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      if (w_out_xfer) begin
        if (w_last_x && w_last_y) begin
          r_x           <= '0;
          r_y           <= '0;
          r_frame_done  <= 1'b1;
          r_frame_count <= r_frame_count + 16'd1;
        end else if (w_last_x) begin
          r_x <= '0;
          r_y <= r_y + 1'b1;
        end else begin
          r_x <= r_x + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_pixel_stream_framer.sv
// tb/tb_pixel_stream_framer.sv - randomized self-checking bench for pixel_stream_framer
module tb_pixel_stream_framer;
  import pix_stream_pkg::*;

  localparam int DATA_W   = 8;
  localparam int CHANNELS = 3;
  localparam int IMG_W    = 4;
  localparam int IMG_H    = 2;
  localparam int DEPTH    = 4;
  localparam int PIX_W    = DATA_W * CHANNELS;
  localparam int FRAME_PX = IMG_W * IMG_H;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             clear = 1'b0;
  logic [PIX_W-1:0] in_pixel = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [PIX_W-1:0] out_pixel;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [1:0]       out_x;
  logic [0:0]       out_y;
  logic             out_sof;
  logic             out_eol;
  logic             out_eof;
  logic [2:0]       fifo_level;
  logic             frame_done;
  logic [15:0]      frame_count;

  always #5 clk = ~clk;

  pixel_stream_framer #(
    .DATA_W(DATA_W), .CHANNELS(CHANNELS), .IMG_W(IMG_W), .IMG_H(IMG_H), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_pixel(in_pixel), .in_valid(in_valid), .in_ready(in_ready),
    .out_pixel(out_pixel), .out_valid(out_valid), .out_ready(out_ready),
    .out_x(out_x), .out_y(out_y), .out_sof(out_sof), .out_eol(out_eol), .out_eof(out_eof),
    .fifo_level(fifo_level), .frame_done(frame_done), .frame_count(frame_count)
  );

  int n_err = 0;
  int n_chk = 0;

  // Reference: pixels in flight, index of the head pixel within its frame, frame totals.
  logic [PIX_W-1:0] q[$];
  int               m_idx;
  logic [15:0]      m_fc;
  logic             m_fd;
  bit               m_acc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_idx = 0;
    m_fc  = '0;
    m_fd  = 1'b0;
  endtask

  task automatic drive(input bit v, input logic [PIX_W-1:0] p, input bit r);
    in_valid  = v;
    in_pixel  = p;
    out_ready = r;
  endtask

  task automatic step();
    bit exp_vld, exp_rdy, ixf, oxf;
    int x, y;
    @(negedge clk);
    exp_vld = (q.size() != 0);
    exp_rdy = (q.size() < DEPTH) && !clear;
    x = m_idx % IMG_W;
    y = m_idx / IMG_W;
    check("out_valid", out_valid, exp_vld);
    check("in_ready", in_ready, exp_rdy);
    check("fifo_level", fifo_level, q.size());
    check("out_x", out_x, x);
    check("out_y", out_y, y);
    check("out_sof", out_sof, exp_vld && m_idx == 0);
    check("out_eol", out_eol, exp_vld && x == IMG_W - 1);
    check("out_eof", out_eof, exp_vld && m_idx == FRAME_PX - 1);
    check("frame_done", frame_done, m_fd);
    check("frame_count", frame_count, m_fc);
    if (exp_vld) check("out_pixel", out_pixel, q[0]);
    ixf = in_valid && exp_rdy;
    oxf = exp_vld && out_ready && !clear;
    @(posedge clk);
    #1;
    m_acc = ixf;
    m_fd  = 1'b0;
    if (clear) begin
      q.delete();
      m_idx = 0;
    end else begin
      if (oxf) begin
        void'(q.pop_front());
        if (m_idx == FRAME_PX - 1) begin
          m_idx = 0;
          m_fc  = m_fc + 16'd1;
          m_fd  = 1'b1;
        end else begin
          m_idx++;
        end
      end
      if (ixf) q.push_back(in_pixel);
    end
  endtask

  task automatic clear_step();
    drive(0, '0, 1);
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  initial begin
    int k;
    logic [15:0] fc_saved;

    // Reset state
    #1 rst_n = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_level", fifo_level, 0);
    check("rst_fcount", frame_count, 0);
    check("rst_fdone", frame_done, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk) #1;

    // One full frame back-to-back
    for (int p = 1; p <= FRAME_PX; p++) begin
      drive(1, PIX_W'(p), 1);
      step();
    end
    drive(0, '0, 1);
    repeat (3) step();
    check("frame1_count", frame_count, 1);

    // Backpressure: four fit, the fifth waits until a read frees a slot
    k = 0;
    for (int c = 0; c < 20 && k < 5; c++) begin
      drive(1, PIX_W'(32'h100 + k), c >= 6);
      step();
      if (m_acc) k++;
      if (c == 5) check("bp_level_full", fifo_level, DEPTH);
    end
    check("bp_all_accepted", k, 5);
    drive(0, '0, 1);
    repeat (6) step();

    // Steady state at level 2 with simultaneous transfers
    drive(1, 24'h200, 0); step();
    drive(1, 24'h201, 0); step();
    for (int c = 0; c < 10; c++) begin
      drive(1, PIX_W'(32'h210 + c), 1);
      step();
      check("sim_level", fifo_level, 2);
    end
    drive(0, '0, 1);
    repeat (4) step();

    // Clear mid-frame at x=2, y=1, level=3
    clear_step();
    for (int c = 0; c < 7; c++) begin
      drive(1, PIX_W'(32'h300 + c), 1);
      step();
    end
    drive(1, 24'h307, 0); step();
    drive(1, 24'h308, 0); step();
    check("pre_clr_x", out_x, 2);
    check("pre_clr_y", out_y, 1);
    check("pre_clr_level", fifo_level, 3);
    fc_saved = frame_count;
    clear_step();
    check("clr_level", fifo_level, 0);
    check("clr_valid", out_valid, 0);
    check("clr_fcount", frame_count, fc_saved);
    drive(1, 24'h400, 1);
    step();
    check("clr_sof", out_sof, 1);
    drive(0, '0, 1);
    repeat (2) step();

    // Asynchronous reset between edges
    for (int c = 0; c < 3; c++) begin
      drive(1, PIX_W'(32'h500 + c), 1);
      step();
    end
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", out_valid, 0);
    check("arst_ready", in_ready, 0);
    check("arst_level", fifo_level, 0);
    check("arst_fcount", frame_count, 0);
    model_reset();
    drive(0, '0, 1);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk) #1;
    drive(1, 24'h600, 1);
    step();
    check("arst_sof", out_sof, 1);

    // Randomized traffic with occasional flushes
    for (int c = 0; c < 3000; c++) begin
      drive($urandom_range(0, 3) != 0, PIX_W'($urandom), $urandom_range(0, 3) != 0);
      clear = ($urandom_range(0, 60) == 0);
      step();
    end
    clear = 1'b0;

    // frame_count wrap from 0xFFFF
    clear_step();
    @(negedge clk);
    #1 force dut.r_frame_count = 16'hFFFF;
    #1 release dut.r_frame_count;
    m_fc = 16'hFFFF;
    @(posedge clk) #1;
    for (int p = 0; p < FRAME_PX; p++) begin
      drive(1, PIX_W'($urandom), 1);
      step();
    end
    drive(0, '0, 1);
    repeat (3) step();
    check("wrap_fcount", frame_count, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
